// File: rtl/dmux2_buf.sv
// Two-way demultiplexer with a first-word-fall-through FIFO per output channel.
// Destination is chosen by S or by an internal round-robin toggle (MODE=1).
module dmux2_buf #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic                     CK,
   input  logic                     CLR,
   input  logic [W-1:0]             I,
   input  logic                     S,
   input  logic                     MODE,
   input  logic                     IV,
   output logic                     IR,
   output logic [W-1:0]             Z0,
   output logic                     Z0V,
   input  logic                     Z0R,
   output logic [W-1:0]             Z1,
   output logic                     Z1V,
   input  logic                     Z1R,
   output logic [$clog2(DEPTH):0]   CNT0,
   output logic [$clog2(DEPTH):0]   CNT1
);

   localparam int        AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic                 tog;
   logic                 dest;
   logic                 accept;
   logic [1:0]           zr;
   logic [1:0]           zv;
   logic [1:0]           full;
   logic [1:0]           push;
   logic [1:0]           pop;
   logic [1:0][W-1:0]    zd;
   logic [1:0][AW:0]     cnt;

   assign zr = {Z1R, Z0R};

   // Full check is taken before any same-cycle pop, so a full FIFO never accepts.
   always_comb begin
      // NOTE: every always_comb output gets a value on every path, or a latch is inferred.
      dest = S;
      if (MODE) dest = tog;
      IR = ~CLR & ~full[dest];
   end

   assign accept = IV & IR;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge CK) begin
      if (CLR)                 tog <= 1'b0;
      else if (accept && MODE) tog <= ~tog;
   end

   for (genvar ch = 0; ch < 2; ch++) begin : g_ch
      logic [W-1:0]  mem [DEPTH];
      logic [AW-1:0] wr_ptr;
      logic [AW-1:0] rd_ptr;
      logic [AW:0]   cnt_r;

      assign cnt[ch]  = cnt_r;
      assign full[ch] = (cnt_r == FULL_CNT);
      assign zv[ch]   = (cnt_r != '0);
      assign push[ch] = accept & (dest == 1'(ch));
      assign pop[ch]  = zv[ch] & zr[ch] & ~CLR;
      assign zd[ch]   = zv[ch] ? mem[rd_ptr] : '0;

      always_ff @(posedge CK) begin
         if (CLR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_r  <= '0;
            // NOTE: storage is cleared on reset so no stale word survives a reset; costs a reset mux per bit.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         end else begin
            if (push[ch]) begin
               mem[wr_ptr] <= I;
               wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop[ch]) rd_ptr <= rd_ptr + 1'b1;
            case ({push[ch], pop[ch]})
               2'b10:   cnt_r <= cnt_r + 1'b1;
               2'b01:   cnt_r <= cnt_r - 1'b1;
               default: cnt_r <= cnt_r;
            endcase
         end
      end
   end

   assign Z0   = zd[0];
   assign Z1   = zd[1];
   assign Z0V  = zv[0];
   assign Z1V  = zv[1];
   assign CNT0 = cnt[0];
   assign CNT1 = cnt[1];

endmodule

// File: tb/tb_dmux2_buf.sv
// Self-checking bench for dmux2_buf: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_dmux2_buf;

   localparam int W     = 8;
   localparam int DEPTH = 2;
   localparam int C     = $clog2(DEPTH) + 1;

   logic          ck = 1'b0;
   logic          clr, s, mode, iv, ir;
   logic [W-1:0]  din, z0, z1;
   logic          z0v, z1v, z0r, z1r;
   logic [C-1:0]  cnt0, cnt1;

   always #5 ck = ~ck;

   dmux2_buf #(.W(W), .DEPTH(DEPTH)) dut (
      .CK(ck), .CLR(clr), .I(din), .S(s), .MODE(mode), .IV(iv), .IR(ir),
      .Z0(z0), .Z0V(z0v), .Z0R(z0r),
      .Z1(z1), .Z1V(z1v), .Z1R(z1r),
      .CNT0(cnt0), .CNT1(cnt1)
   );

   int tests = 0;
   int fails = 0;

   logic [W-1:0] q0[$];
   logic [W-1:0] q1[$];
   logic [W-1:0] rx1[$];
   bit           t_m = 1'b0;
   int           max_cnt1 = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] head(input int ch);
      if (ch == 0) return (q0.size() != 0) ? 32'(q0[0]) : 32'd0;
      return (q1.size() != 0) ? 32'(q1[0]) : 32'd0;
   endfunction

   // Compare every DUT output against the model state before the edge.
   task automatic compare();
      bit d;
      int occ;
      d   = mode ? t_m : s;
      occ = d ? q1.size() : q0.size();
      check("IR",   ir,   32'(!clr && occ < DEPTH));
      check("Z0V",  z0v,  32'(q0.size() != 0));
      check("Z0",   z0,   head(0));
      check("CNT0", cnt0, 32'(q0.size()));
      check("Z1V",  z1v,  32'(q1.size() != 0));
      check("Z1",   z1,   head(1));
      check("CNT1", cnt1, 32'(q1.size()));
   endtask

   task automatic cycle(input logic c, input logic v, input logic sel, input logic m,
                        input logic [W-1:0] d, input logic r0, input logic r1);
      bit dd, acc, p0, p1;
      @(negedge ck);
      clr = c; iv = v; s = sel; mode = m; din = d; z0r = r0; z1r = r1;
      #1;
      compare();
      dd  = mode ? t_m : s;
      acc = !clr && iv && ((dd ? q1.size() : q0.size()) < DEPTH);
      p0  = !clr && z0r && q0.size() > 0;
      p1  = !clr && z1r && q1.size() > 0;
      if (p1) rx1.push_back(z1);
      @(posedge ck);
      if (clr) begin
         q0.delete(); q1.delete(); t_m = 1'b0;
      end else begin
         if (p0) void'(q0.pop_front());
         if (p1) void'(q1.pop_front());
         if (acc) begin
            if (dd) q1.push_back(din);
            else    q0.push_back(din);
            if (mode) t_m = ~t_m;
         end
      end
      if (q1.size() > max_cnt1) max_cnt1 = q1.size();
      #1;
   endtask

   initial begin
      clr = 1'b1; iv = 1'b0; s = 1'b0; mode = 1'b0; din = '0; z0r = 1'b0; z1r = 1'b0;
      cycle(1, 0, 0, 0, 8'h00, 0, 0);
      cycle(1, 0, 0, 0, 8'h00, 0, 0);
      check("rst_z0v", z0v, 0);
      check("rst_cnt0", cnt0, 0);
      check("rst_z1", z1, 0);

      // Routing by S
      cycle(0, 1, 0, 0, 8'h11, 0, 0);
      check("route_z0", z0, 32'h11);
      check("route_z1v_idle", z1v, 0);
      cycle(0, 1, 1, 0, 8'h22, 0, 0);
      check("route_z1", z1, 32'h22);
      check("route_z1v", z1v, 1);
      cycle(0, 0, 0, 0, 8'h00, 1, 1);
      check("route_drain", {cnt0, cnt1}, 0);

      // Alternation with both consumers stalled
      for (int k = 0; k < 4; k++) cycle(0, 1, 0, 1, 8'hA0 + 8'(k), 0, 0);
      check("alt_z0", z0, 32'hA0);
      check("alt_z1", z1, 32'hA1);
      check("alt_cnt0", cnt0, 2);
      check("alt_cnt1", cnt1, 2);
      cycle(0, 0, 0, 1, 8'h00, 1, 0);
      check("alt_z0_next", z0, 32'hA2);
      cycle(0, 0, 0, 1, 8'h00, 0, 1);
      check("alt_z1_next", z1, 32'hA3);
      cycle(0, 0, 0, 1, 8'h00, 1, 1);

      // Full / backpressure on channel 0
      cycle(0, 1, 0, 0, 8'h31, 0, 0);
      cycle(0, 1, 0, 0, 8'h32, 0, 0);
      check("full_ir", ir, 0);
      check("full_cnt0", cnt0, 2);
      cycle(0, 1, 0, 0, 8'h33, 1, 0);
      check("full_after_pop_cnt", cnt0, 1);
      check("full_after_pop_ir", ir, 1);
      check("full_after_pop_z0", z0, 32'h32);
      cycle(0, 1, 0, 0, 8'h33, 0, 0);
      check("full_third_cnt", cnt0, 2);
      cycle(0, 0, 0, 0, 8'h00, 1, 0);
      check("full_third_head", z0, 32'h33);
      cycle(0, 0, 0, 0, 8'h00, 1, 0);

      // Simultaneous push and pop
      cycle(0, 1, 0, 0, 8'h44, 0, 0);
      cycle(0, 1, 0, 0, 8'h55, 1, 0);
      check("pp_cnt0", cnt0, 1);
      check("pp_z0", z0, 32'h55);
      cycle(0, 0, 0, 0, 8'h00, 1, 0);

      // Pointer wrap through channel 1
      rx1.delete();
      max_cnt1 = 0;
      for (int k = 0; k < 20; k++) cycle(0, 1, 1, 0, 8'h60 + 8'(k), 0, 1);
      cycle(0, 0, 0, 0, 8'h00, 0, 1);
      cycle(0, 0, 0, 0, 8'h00, 0, 1);
      check("wrap_count", rx1.size(), 20);
      for (int k = 0; k < rx1.size() && k < 20; k++) check("wrap_order", rx1[k], 32'h60 + k);
      check("wrap_max", 32'(max_cnt1 <= DEPTH), 1);

      // Reset mid-operation, with T set beforehand
      cycle(0, 1, 0, 1, 8'h71, 0, 0);
      cycle(0, 1, 0, 0, 8'h72, 0, 0);
      cycle(0, 1, 1, 0, 8'h73, 0, 0);
      check("pre_rst_cnt0", cnt0, 2);
      check("pre_rst_cnt1", cnt1, 1);
      cycle(1, 1, 1, 1, 8'h74, 1, 1);
      check("mid_rst_cnt", {cnt0, cnt1}, 0);
      check("mid_rst_zv", {z0v, z1v}, 0);
      cycle(0, 1, 1, 1, 8'h75, 0, 0);
      check("post_rst_t0_dest", z0, 32'h75);
      check("post_rst_z1v", z1v, 0);

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         cycle(($urandom % 100) == 0, ($urandom % 10) < 7, 1'($urandom), ($urandom % 4) == 0 ? ~mode : mode,
               8'($urandom), ($urandom % 2) == 0, ($urandom % 3) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dmux2_buf.md
DMUX2_BUF -- requirements
Module: dmux2_buf

Interface
REQ-001 SHALL have parameter W, default 8, giving the data width in bits (1..32).
REQ-002 SHALL have parameter DEPTH, default 2, giving per-output FIFO depth (power of 2, 2..16); C = log2(DEPTH)+1.
REQ-003 SHALL have port CK  in  1  rising-edge clock, the only clock.
REQ-004 SHALL have port CLR  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port I  in  W  input data.
REQ-006 SHALL have port S  in  1  destination select (0 -> Z0, 1 -> Z1), used when MODE=0.
REQ-007 SHALL have port MODE  in  1  0 = routed by S, 1 = alternating (round-robin).
REQ-008 SHALL have port IV  in  1  input valid.
REQ-009 SHALL have port IR  out  1  input ready.
REQ-010 SHALL have port Z0  out  W  channel 0 head data.
REQ-011 SHALL have port Z0V  out  1  channel 0 valid.
REQ-012 SHALL have port Z0R  in  1  channel 0 ready from consumer.
REQ-013 SHALL have ports Z1, Z1V, Z1R, identical to Z0, Z0V, Z0R for channel 1.
REQ-014 SHALL have ports CNT0 and CNT1  out  C  occupancy of each channel FIFO.

Function
REQ-015 SHALL take destination d = S when MODE=0, and d = internal toggle bit T when MODE=1.
REQ-016 SHALL drive IR = 1 only when CLR=0 and FIFO d is not full; IR is combinational from S, MODE, T and occupancy.
REQ-017 SHALL accept input on a cycle with IV=1 and IR=1, and write I into FIFO d at that CK edge.
REQ-018 SHALL hold I, S and MODE as don't-care on cycles with IV=0, with no state change from the input side.
REQ-019 SHALL make each FIFO first-word-fall-through: ZnV = (CNTn != 0), and Zn = oldest entry.
REQ-020 SHALL have latency of exactly 1 cycle: a word accepted at edge k is visible on Zn/ZnV after edge k; there is no same-cycle bypass.
REQ-021 SHALL pop channel n on a cycle with ZnV=1 and ZnR=1; ZnR is ignored when ZnV=0.
REQ-022 SHALL hold Zn and ZnV stable while ZnV=1 and ZnR=0.
REQ-023 SHALL leave CNTn unchanged and advance both pointers on a simultaneous push and pop to the same non-empty FIFO.
REQ-024 SHALL keep IR=0 for d when FIFO d is full, even if a pop of d occurs that cycle.
REQ-025 SHALL wrap read and write pointers modulo DEPTH; CNTn ranges 0..DEPTH.
REQ-026 SHALL toggle T only on an accepted transfer while MODE=1; T holds otherwise, including while MODE=0.
REQ-027 SHALL apply a MODE change to the next transfer decision combinationally; in-flight FIFO contents are unaffected.
REQ-028 SHALL operate the two channels independently: pops on one channel never affect the other, and both may pop in the same cycle.
REQ-029 SHALL show Zn = 0 when CNTn = 0.

Reset
REQ-030 SHALL, on a CK edge with CLR=1, clear CNT0, CNT1, all pointers, T and all FIFO storage to 0.
REQ-031 SHALL drive IR=0 whenever CLR=1; Z0V=Z1V=0 and Z0=Z1=0 after the reset edge.
REQ-032 SHALL discard any push or pop coinciding with a CLR=1 edge, including a reset that occurs mid-stream.

Verification
REQ-033 SHALL check routing: MODE=0, send 0x11 (S=0) then 0x22 (S=1) -> Z0=0x11 and Z1=0x22, each valid exactly 1 cycle after its accept.
REQ-034 SHALL check alternation: MODE=1, T=0, send 0xA0, 0xA1, 0xA2, 0xA3 with both consumers stalled -> Z0 holds 0xA0 then 0xA2; Z1 holds 0xA1 then 0xA3; CNT0=CNT1=2.
REQ-035 SHALL check full/backpressure: DEPTH=2, Z0R=0, three words with S=0 -> third sees IR=0, CNT0=2; then Z0R=1 for one cycle -> IR=1 the following cycle and the third word is accepted.
REQ-036 SHALL check simultaneous push/pop: CNT0=1, push 0x55 and pop in the same cycle -> CNT0 stays 1 and Z0 becomes 0x55.
REQ-037 SHALL check pointer wrap: 20 words streamed through Z1 with Z1R=1 -> output order identical to input order, CNT1 never exceeds DEPTH.
REQ-038 SHALL check reset mid-operation: CNT0=2, CNT1=1, CLR=1 for one edge -> all CNT=0, ZnV=0, T=0, IR=0 during CLR, IR=1 on the cycle after.
